// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter and press/hold FSM.
// Define BTN_AUTOREPEAT_EN to build the auto-repeat timer in the LONG state.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES    = 250_000,
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic clk_25mhz,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic btn_level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DEB_W     = $clog2(DEB_CYCLES);
  // The hold counter doubles as the repeat timer, so it must span both periods.
  localparam int unsigned HOLD_SPAN = (REPEAT_CYCLES > LONG_CYCLES) ? REPEAT_CYCLES : LONG_CYCLES;
  localparam int unsigned HOLD_W    = $clog2(HOLD_SPAN);

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 32'd1);
  localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1'b1);
  localparam logic [DEB_W-1:0]  DEB_ZERO = {DEB_W{1'b0}};
  localparam logic [HOLD_W-1:0] LONG_PRE = HOLD_W'(LONG_CYCLES - 32'd2);
  localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1'b1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LAST = HOLD_W'(REPEAT_CYCLES - 32'd1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  logic              pin_s;
  logic              sync_meta_r;
  logic              sync_r;
  logic              sync_s;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic [DEB_W-1:0]  deb_cnt_nxt_s;
  logic              level_r;
  logic              level_nxt_s;
  logic              flip_s;
  logic              rise_s;
  logic              fall_s;
  logic              press_r;
  logic              release_r;
  state_t            state_r;
  state_t            state_nxt_s;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_nxt_s;
  logic              long_r;
  logic              long_nxt_s;
`ifdef BTN_AUTOREPEAT_EN
  logic              repeat_r;
  logic              repeat_nxt_s;
`endif

  assign pin_s  = btn_i ^ ACTIVE_LOW;
  assign sync_s = sync_r;

  // Two-flop synchroniser on the polarity-corrected pin.
  always_ff @(posedge clk_25mhz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= pin_s;
      sync_r      <= sync_meta_r;
    end
  end

  // Debounce: count cycles of disagreement, flip the level after DEB_CYCLES of them.
  always_comb begin
    deb_cnt_nxt_s = deb_cnt_r;
    level_nxt_s   = level_r;
    flip_s        = 1'b0;
    if (sync_s == level_r) begin
      deb_cnt_nxt_s = DEB_ZERO;
    end else if (deb_cnt_r == DEB_LAST) begin
      flip_s        = 1'b1;
      level_nxt_s   = ~level_r;
      deb_cnt_nxt_s = DEB_ZERO;
    end else begin
      deb_cnt_nxt_s = deb_cnt_r + DEB_ONE;
    end
  end

  assign rise_s = flip_s & ~level_r;
  assign fall_s = flip_s & level_r;

  // Debounced level and its edge pulses, registered on the flip edge itself.
  always_ff @(posedge clk_25mhz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      deb_cnt_r <= DEB_ZERO;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      deb_cnt_r <= deb_cnt_nxt_s;
      level_r   <= level_nxt_s;
      press_r   <= rise_s;
      release_r <= fall_s;
    end
  end

  // Press/hold FSM next state; a release edge always wins over long/repeat events.
  always_comb begin
    state_nxt_s  = state_r;
    hold_nxt_s   = hold_r;
    long_nxt_s   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_nxt_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        hold_nxt_s = HOLD_ZERO;
        if (rise_s) begin
          state_nxt_s = ST_HELD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (fall_s) begin
          state_nxt_s = ST_IDLE;
          hold_nxt_s  = HOLD_ZERO;
        end else if (hold_r == LONG_PRE) begin
          state_nxt_s = ST_LONG;
          long_nxt_s  = 1'b1;
          hold_nxt_s  = HOLD_ZERO;
        end else if (hold_r != HOLD_MAX) begin
          hold_nxt_s  = hold_r + HOLD_ONE;
        end else begin
          hold_nxt_s  = hold_r;
        end
      end
      ST_LONG: begin
        if (fall_s) begin
          state_nxt_s = ST_IDLE;
          hold_nxt_s  = HOLD_ZERO;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (hold_r == REP_LAST) begin
            repeat_nxt_s = 1'b1;
            hold_nxt_s   = HOLD_ZERO;
          end else begin
            hold_nxt_s   = hold_r + HOLD_ONE;
          end
`else
          hold_nxt_s = HOLD_ZERO;
`endif
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        hold_nxt_s  = HOLD_ZERO;
      end
    endcase
  end

  // FSM state, hold/repeat counter and long-press pulse.
  always_ff @(posedge clk_25mhz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      hold_r  <= HOLD_ZERO;
      long_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
      long_r  <= long_nxt_s;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Auto-repeat pulse register.
  always_ff @(posedge clk_25mhz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      repeat_r <= 1'b0;
    end else begin
      repeat_r <= repeat_nxt_s;
    end
  end

  assign repeat_o = repeat_r;
`else
  assign repeat_o = 1'b0;
`endif

  assign btn_level_o = level_r;
  assign press_o     = press_r;
  assign release_o   = release_r;
  assign long_o      = long_r;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: an active-high and an active-low instance share
// one stimulus stream and are compared against an event-timestamp reference model.
module tb_btn_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk_s = 1'b0;
  logic rst_n;
  logic btn_a;
  logic btn_b;
  logic lvl_a, press_a, rel_a, long_a, rep_a;
  logic lvl_b, press_b, rel_b, long_b, rep_b;
  logic [4:0] obs_a, obs_b;

  always #20 clk_s = ~clk_s;

  assign btn_b = ~btn_a;
  assign obs_a = {lvl_a, press_a, rel_a, long_a, rep_a};
  assign obs_b = {lvl_b, press_b, rel_b, long_b, rep_b};

  btn_debounce #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk_25mhz(clk_s), .rst_n_i(rst_n), .btn_i(btn_a), .btn_level_o(lvl_a),
    .press_o(press_a), .release_o(rel_a), .long_o(long_a), .repeat_o(rep_a));

  btn_debounce #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk_25mhz(clk_s), .rst_n_i(rst_n), .btn_i(btn_b), .btn_level_o(lvl_b),
    .press_o(press_b), .release_o(rel_b), .long_o(long_b), .repeat_o(rep_b));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pressed-ness delayed two edges, a run-length of disagreement,
  // and timestamps of the press and long events from which later events are derived.
  bit   pipe_q[$];
  int   m_edge;
  bit   m_level;
  int   m_streak;
  bit   m_held;
  bit   m_long;
  int   m_press_e;
  int   m_long_e;
  logic [4:0] exp_v;

  task automatic model_reset();
    pipe_q    = '{1'b0, 1'b0};
    m_edge    = 0;
    m_level   = 1'b0;
    m_streak  = 0;
    m_held    = 1'b0;
    m_long    = 1'b0;
    m_press_e = 0;
    m_long_e  = 0;
    exp_v     = 5'b00000;
  endtask

  task automatic model_step();
    bit seen;
    bit rise = 1'b0;
    bit fall = 1'b0;
    bit lp   = 1'b0;
    bit rp   = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_edge++;
    seen = pipe_q.pop_front();
    pipe_q.push_back(btn_a);
    if (seen != m_level) begin
      m_streak++;
      if (m_streak == DEB) begin
        rise     = !m_level;
        fall     = m_level;
        m_level  = !m_level;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    if (rise) begin
      m_held    = 1'b1;
      m_long    = 1'b0;
      m_press_e = m_edge;
    end else if (fall) begin
      m_held = 1'b0;
      m_long = 1'b0;
    end else if (m_held && !m_long && (m_edge - m_press_e == LONG - 1)) begin
      lp       = 1'b1;
      m_long   = 1'b1;
      m_long_e = m_edge;
    end else if (m_held && m_long && AUTOREP && (m_edge > m_long_e) && ((m_edge - m_long_e) % REP == 0)) begin
      rp = 1'b1;
    end
    exp_v = {m_level, rise, fall, lp, rp};
  endtask

  task automatic step(input bit b);
    btn_a = b;
    @(posedge clk_s);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_a = 1'b0;
    model_reset();
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_a = 1'b1;
    model_reset();
    step(1'b1);
    step(1'b1);
    n_checks++;
    if ({obs_a, obs_b} !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_state: got a=%b b=%b exp 00000", obs_a, obs_b);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(1'b0);
      n_checks++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        n_errors++;
        $display("FAIL reset_idle cycle %0d: got a=%b b=%b exp %b", c, obs_a, obs_b, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    int press_e = -1;
    int rel_e   = -1;
    int long_n  = 0;
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      step(c <= 10);
      n_checks++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        n_errors++;
        $display("FAIL clean_press cycle %0d: got a=%b b=%b exp %b", c, obs_a, obs_b, exp_v);
      end
      if (press_a && press_e < 0) press_e = c;
      if (rel_a && rel_e < 0) rel_e = c;
      if (long_a) long_n++;
    end
    n_checks++;
    if (press_e !== 6) begin
      n_errors++;
      $display("FAIL clean_press_edge: got %0d exp 6", press_e);
    end
    n_checks++;
    if (rel_e !== 16) begin
      n_errors++;
      $display("FAIL clean_release_edge: got %0d exp 16", rel_e);
    end
    n_checks++;
    if (long_n !== 0) begin
      n_errors++;
      $display("FAIL clean_no_long: got %0d exp 0", long_n);
    end
  endtask

  task automatic test_glitch();
    int any_n = 0;
    int c = 0;
    int on_len, off_len;
    do_reset();
    for (int r = 0; r < 26; r++) begin
      on_len  = (r < 6) ? 3 : int'($urandom_range(1, DEB - 1));
      off_len = (r < 6) ? 3 : int'($urandom_range(1, 4));
      for (int k = 0; k < on_len + off_len; k++) begin
        c++;
        step(k < on_len);
        n_checks++;
        if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
          n_errors++;
          $display("FAIL glitch cycle %0d: got a=%b b=%b exp %b", c, obs_a, obs_b, exp_v);
        end
        if ((obs_a | obs_b) != 5'b00000) any_n++;
      end
    end
    n_checks++;
    if (any_n !== 0) begin
      n_errors++;
      $display("FAIL glitch_quiet: got %0d active cycles exp 0", any_n);
    end
  endtask

  task automatic test_long_hold();
    int press_e = -1;
    int long_e  = -1;
    int rel_e   = -1;
    int rep_n   = 0;
    do_reset();
    for (int c = 1; c <= 54; c++) begin
      step(c <= 40);
      n_checks++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        n_errors++;
        $display("FAIL long_hold cycle %0d: got a=%b b=%b exp %b", c, obs_a, obs_b, exp_v);
      end
      if (press_a && press_e < 0) press_e = c;
      if (long_a && long_e < 0) long_e = c;
      if (rel_a && rel_e < 0) rel_e = c;
      if (rep_a) rep_n++;
    end
    n_checks++;
    if ({press_e, long_e, rel_e} !== {32'sd6, 32'sd25, 32'sd46}) begin
      n_errors++;
      $display("FAIL long_hold_edges: got press %0d long %0d release %0d exp 6 25 46", press_e, long_e, rel_e);
    end
    n_checks++;
    if (rep_n !== (AUTOREP ? 2 : 0)) begin
      n_errors++;
      $display("FAIL long_hold_repeats: got %0d exp %0d", rep_n, AUTOREP ? 2 : 0);
    end
  endtask

  task automatic test_autorepeat();
    int long_e    = -1;
    int first_rep = -1;
    int rel_e     = -1;
    int rep_n     = 0;
    int rep_after = 0;
    do_reset();
    for (int c = 1; c <= 80; c++) begin
      step(c <= 60);
      n_checks++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        n_errors++;
        $display("FAIL autorepeat cycle %0d: got a=%b b=%b exp %b", c, obs_a, obs_b, exp_v);
      end
      if (long_a && long_e < 0) long_e = c;
      if (rel_a && rel_e < 0) rel_e = c;
      if (rep_a) begin
        rep_n++;
        if (first_rep < 0) first_rep = c;
        if (rel_e >= 0) rep_after++;
      end
    end
    n_checks++;
    if (long_e !== 25) begin
      n_errors++;
      $display("FAIL autorepeat_long: got %0d exp 25", long_e);
    end
    n_checks++;
    if (first_rep !== (AUTOREP ? 33 : -1)) begin
      n_errors++;
      $display("FAIL autorepeat_first: got %0d exp %0d", first_rep, AUTOREP ? 33 : -1);
    end
    n_checks++;
    if (rep_n !== (AUTOREP ? 5 : 0) || rep_after !== 0) begin
      n_errors++;
      $display("FAIL autorepeat_count: got %0d (%0d after release) exp %0d (0)", rep_n, rep_after, AUTOREP ? 5 : 0);
    end
  endtask

  task automatic test_reset_mid_press();
    int press_k = -1;
    int long_k  = -1;
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      step(1'b1);
      n_checks++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        n_errors++;
        $display("FAIL mid_reset_pre cycle %0d: got a=%b b=%b exp %b", c, obs_a, obs_b, exp_v);
      end
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({obs_a, obs_b} !== 10'b0) begin
      n_errors++;
      $display("FAIL mid_reset_async: got a=%b b=%b exp 00000", obs_a, obs_b);
    end
    for (int c = 1; c <= 2; c++) begin
      step(1'b1);
      n_checks++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        n_errors++;
        $display("FAIL mid_reset_hold cycle %0d: got a=%b b=%b exp %b", c, obs_a, obs_b, exp_v);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step(1'b1);
      n_checks++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        n_errors++;
        $display("FAIL mid_reset_post cycle %0d: got a=%b b=%b exp %b", k, obs_a, obs_b, exp_v);
      end
      if (press_a && press_k < 0) press_k = k;
      if (long_a && long_k < 0) long_k = k;
    end
    n_checks++;
    if (press_k !== 6 || (long_k - press_k) !== 19) begin
      n_errors++;
      $display("FAIL mid_reset_timing: got press %0d long-press %0d exp 6 19", press_k, long_k - press_k);
    end
  endtask

  task automatic test_active_low();
    int press_e = -1;
    logic lvl_at10 = 1'b0;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step(c <= 10);
      n_checks++;
      if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
        n_errors++;
        $display("FAIL active_low cycle %0d: got a=%b b=%b exp %b", c, obs_a, obs_b, exp_v);
      end
      if (press_b && press_e < 0) press_e = c;
      if (c == 10) lvl_at10 = lvl_b;
    end
    n_checks++;
    if (press_e !== 6 || lvl_at10 !== 1'b1) begin
      n_errors++;
      $display("FAIL active_low_press: got edge %0d level %b exp 6 1", press_e, lvl_at10);
    end
  endtask

  task automatic test_random();
    bit v = 1'b0;
    int c = 0;
    int len;
    do_reset();
    for (int r = 0; r < 40; r++) begin
      v   = !v;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70)) : int'($urandom_range(1, 10));
      for (int k = 0; k < len; k++) begin
        c++;
        step(v);
        n_checks++;
        if ({obs_a, obs_b} !== {exp_v, exp_v}) begin
          n_errors++;
          $display("FAIL random cycle %0d: got a=%b b=%b exp %b", c, obs_a, obs_b, exp_v);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_a = 1'b0;
    model_reset();
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_hold();
    test_autorepeat();
    test_reset_mid_press();
    test_active_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
